// File: rtl/exec_pkg.sv
// Shared types for the execution-phase sequencer: one-hot phase codes,
// sub-phase states, enter-request priority order and memory-phase test.
package exec_pkg;

  typedef enum logic [9:0] {
    PH_NONE = 10'b0000000000,
    PH_PP   = 10'b0000000001,
    PH_WS   = 10'b0000000010,
    PH_WZ   = 10'b0000000100,
    PH_WE   = 10'b0000001000,
    PH_WP   = 10'b0000010000,
    PH_WA   = 10'b0000100000,
    PH_WR   = 10'b0001000000,
    PH_WW   = 10'b0010000000,
    PH_WM   = 10'b0100000000,
    PH_WX   = 10'b1000000000
  } phase_t;

  typedef enum logic [1:0] {
    SP_IDLE,
    SP_S1,
    SP_MW,
    SP_S2
  } subph_t;

  localparam int unsigned N_ENTER = 9;

  // Request vector bit i selects ENTER_PRIO[i]; lower index wins.
  localparam phase_t ENTER_PRIO [N_ENTER] = '{
    PH_WP, PH_WA, PH_WE, PH_WZ, PH_WS, PH_WR, PH_WW, PH_WM, PH_WX
  };

  function automatic logic is_mem_phase(input phase_t p);
    return (p == PH_WR) || (p == PH_WW) || (p == PH_WM);
  endfunction

endpackage

// File: rtl/exec_seq_prio.sv
// Priority encoder for the decoder's enter-phase requests: one-hot next
// phase plus flags for "any request" and "more than one request".
module exec_prio
  import exec_pkg::*;
(
  input  logic [N_ENTER-1:0] ew,
  output phase_t             next_phase,
  output logic               any_req,
  output logic               multi_req
);

  always_comb begin
    next_phase = PH_NONE;
    any_req    = 1'b0;
    multi_req  = 1'b0;
    for (int unsigned i = 0; i < N_ENTER; i++) begin
      if (ew[i]) begin
        if (any_req) multi_req = 1'b1;
        else         next_phase = ENTER_PRIO[i];
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exec_seq.sv
// Execution-phase sequencer: holds the one-hot phase register, strobes each
// phase (or runs the memory handshake) and selects the next phase or end.
module exec_seq
  import exec_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned TO_W        = 7
) (
  input  logic clk_sys,
  input  logic clr_,
  input  logic start,
  input  logic ewa,
  input  logic ewp,
  input  logic ewe,
  input  logic ewz,
  input  logic ews,
  input  logic ewr,
  input  logic ewm,
  input  logic eww,
  input  logic ewx,
  input  logic ekc_1_,
  input  logic ekc_2_,
  input  logic mem_ok,
  output logic pp_,
  output logic ws_,
  output logic wz_,
  output logic we_,
  output logic wp_,
  output logic wa_,
  output logic wr_,
  output logic ww_,
  output logic wm_,
  output logic wx_,
  output logic strob1,
  output logic strob2,
  output logic mem_req,
  output logic kc,
  output logic busy,
  output logic alarm
);

  subph_t          sp, sp_nxt;
  phase_t          phase, phase_nxt;
  logic [TO_W-1:0] cnt, cnt_nxt;
  logic            kc_nxt, alarm_nxt;

  phase_t          prio_phase;
  logic            any_req, multi_req;

  exec_prio u_prio (
    .ew         ({ewx, ewm, eww, ewr, ews, ewz, ewe, ewa, ewp}),
    .next_phase (prio_phase),
    .any_req    (any_req),
    .multi_req  (multi_req)
  );

  always_ff @(posedge clk_sys or negedge clr_) begin
    if (!clr_) begin
      sp    <= SP_IDLE;
      phase <= PH_NONE;
      cnt   <= '0;
      kc    <= 1'b0;
      alarm <= 1'b0;
    end else begin
      sp    <= sp_nxt;
      phase <= phase_nxt;
      cnt   <= cnt_nxt;
      kc    <= kc_nxt;
      alarm <= alarm_nxt;
    end
  end

  // An accepted start loads PP while still in IDLE; the loaded phase then
  // arms S1 on the following edge, giving PP one extra flagged cycle.
  always_comb begin
    sp_nxt    = sp;
    phase_nxt = phase;
    cnt_nxt   = cnt;
    kc_nxt    = 1'b0;
    alarm_nxt = alarm;
    unique case (sp)
      SP_IDLE: begin
        if (phase != PH_NONE) sp_nxt = SP_S1;
        else if (start)       phase_nxt = PH_PP;
      end
      SP_S1: begin
        sp_nxt = is_mem_phase(phase) ? SP_MW : SP_S2;
      end
      SP_MW: begin
        if (mem_ok) begin
          sp_nxt  = SP_S2;
          cnt_nxt = '0;
        end else if (cnt == TO_W'(MEM_TIMEOUT - 1)) begin
          sp_nxt    = SP_IDLE;
          phase_nxt = PH_NONE;
          cnt_nxt   = '0;
          alarm_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      SP_S2: begin
        if (!ekc_1_ || !ekc_2_) begin
          sp_nxt    = SP_IDLE;
          phase_nxt = PH_NONE;
          kc_nxt    = 1'b1;
        end else if (any_req) begin
          sp_nxt    = SP_S1;
          phase_nxt = prio_phase;
          if (multi_req) alarm_nxt = 1'b1;
        end else begin
          sp_nxt    = SP_IDLE;
          phase_nxt = PH_NONE;
          alarm_nxt = 1'b1;
        end
      end
      default: begin
        sp_nxt    = SP_IDLE;
        phase_nxt = PH_NONE;
      end
    endcase
  end

  always_comb begin
    strob1  = (sp == SP_S1);
    strob2  = (sp == SP_S2);
    mem_req = (sp == SP_MW) || ((sp == SP_S1) && is_mem_phase(phase));
    busy    = (sp != SP_IDLE) || (phase != PH_NONE);
    {wx_, wm_, ww_, wr_, wa_, wp_, we_, wz_, ws_, pp_} = ~phase;
  end

endmodule

// File: tb/tb_exec_seq.sv
// Scoreboard bench for exec_seq: driver pushes expected phase entries / kc
// pulses, a negedge monitor pops and compares them as the DUT presents them.
module tb_exec_seq;

  logic       clk_sys = 1'b0;
  logic       clr_    = 1'b0;
  logic       start   = 1'b0;
  logic       mem_ok  = 1'b0;
  logic       ekc_1_  = 1'b1;
  logic       ekc_2_  = 1'b1;
  logic [9:0] ewv     = '0;   // indexed by phase number: 1=WS .. 9=WX
  logic pp_, ws_, wz_, we_, wp_, wa_, wr_, ww_, wm_, wx_;
  logic strob1, strob2, mem_req, kc, busy, alarm;
  logic [9:0] flags;

  assign flags = {wx_, wm_, ww_, wr_, wa_, wp_, we_, wz_, ws_, pp_};

  always #5 clk_sys = ~clk_sys;

  exec_seq #(.MEM_TIMEOUT(64), .TO_W(7)) dut (
    .clk_sys (clk_sys), .clr_ (clr_), .start (start),
    .ewa (ewv[5]), .ewp (ewv[4]), .ewe (ewv[3]), .ewz (ewv[2]), .ews (ewv[1]),
    .ewr (ewv[6]), .ewm (ewv[8]), .eww (ewv[7]), .ewx (ewv[9]),
    .ekc_1_ (ekc_1_), .ekc_2_ (ekc_2_), .mem_ok (mem_ok),
    .pp_ (pp_), .ws_ (ws_), .wz_ (wz_), .we_ (we_), .wp_ (wp_), .wa_ (wa_),
    .wr_ (wr_), .ww_ (ww_), .wm_ (wm_), .wx_ (wx_),
    .strob1 (strob1), .strob2 (strob2), .mem_req (mem_req), .kc (kc),
    .busy (busy), .alarm (alarm)
  );

  typedef struct {
    int kind;   // 0: phase entry seen at strob1, 1: kc pulse
    int ph;
    bit alm;
  } exp_t;

  exp_t expq[$];
  int   checks    = 0;
  int   failures  = 0;
  bit   alarm_exp = 1'b0;
  int   kc_exp    = 0;
  int   kc_seen   = 0;
  int   prio [9]  = '{4, 5, 3, 2, 1, 6, 7, 8, 9};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_sys) begin
    if (clr_) begin
      chk("strob_excl", 32'(strob1 & strob2), 0);
      chk("flags_onehot", 32'($countones(~flags) <= 1), 1);
      if (strob1) begin
        if (expq.size() == 0) chk("unexpected_strob1", 1, 0);
        else begin
          exp_t e;
          logic [9:0] ef;
          e  = expq.pop_front();
          ef = ~(10'd1 << e.ph);
          chk("phase_kind", e.kind, 0);
          chk("phase_flags", flags, ef);
          chk("phase_alarm", alarm, e.alm);
        end
      end
      if (kc) begin
        kc_seen++;
        if (expq.size() == 0) chk("unexpected_kc", 1, 0);
        else begin
          exp_t e;
          e = expq.pop_front();
          chk("kc_kind", e.kind, 1);
          chk("kc_flags", flags, 10'h3ff);
          chk("kc_busy", busy, 0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_for(input int which, input string name);
    int n = 0;
    while (!(which == 0 ? strob1 : strob2) && n < 200) begin
      tick();
      n++;
    end
    chk(name, which == 0 ? strob1 : strob2, 1);
  endtask

  task automatic do_start();
    start = 1'b1;
    expq.push_back('{kind: 0, ph: 0, alm: alarm_exp});
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    #2 clr_ = 1'b0;
    #1;
    chk("rst_flags", flags, 10'h3ff);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_strobes", {strob1, strob2, kc}, 0);
    expq.delete();
    alarm_exp = 1'b0;
    @(posedge clk_sys);
    #1 clr_ = 1'b1;
  endtask

  // Called at S1 of a memory phase; d = MW cycle carrying mem_ok, 0 = never.
  task automatic mem_phase(input int d);
    tick();
    if (d == 0) begin
      repeat (63) tick();
      chk("to_busy_c64", busy, 1);
      chk("to_alarm_c64", alarm, alarm_exp);
      chk("to_mem_req_c64", mem_req, 1);
      tick();
      alarm_exp = 1'b1;
      chk("to_alarm", alarm, 1);
      chk("to_idle", busy, 0);
      chk("to_mem_req", mem_req, 0);
      chk("to_flags", flags, 10'h3ff);
      tick();
      chk("to_no_kc", kc, 0);
    end else begin
      repeat (d - 1) tick();
      chk("mw_mem_req", mem_req, 1);
      mem_ok = 1'b1;
      tick();
      mem_ok = 1'b0;
      chk("mw_to_s2", strob2, 1);
      chk("mw_alarm", alarm, alarm_exp);
    end
  endtask

  // Drive the S2 request inputs and record what the sequencer must do next.
  task automatic decide(input logic [9:0] ew, input bit e1, input bit e2, output int nxt);
    ewv = ew; ekc_1_ = !e1; ekc_2_ = !e2;
    nxt = -1;
    if (e1 || e2) begin
      kc_exp++;
      expq.push_back('{kind: 1, ph: 0, alm: alarm_exp});
    end else if (ew == '0) begin
      alarm_exp = 1'b1;
    end else begin
      foreach (prio[i]) if (nxt < 0 && ew[prio[i]]) nxt = prio[i];
      if ($countones(ew) > 1) alarm_exp = 1'b1;
      expq.push_back('{kind: 0, ph: nxt, alm: alarm_exp});
    end
    tick();
    ewv = '0; ekc_1_ = 1'b1; ekc_2_ = 1'b1;
    if (nxt < 0 && !(e1 || e2)) begin
      chk("err_idle", busy, 0);
      chk("err_alarm", alarm, 1);
      chk("err_no_kc", kc, 0);
    end
  endtask

  task automatic rand_instr();
    int cur, nxt, steps;
    do_start();
    cur = 0; steps = 0;
    while (cur >= 0) begin
      wait_for(0, "rnd_wait_s1");
      if (cur inside {6, 7, 8}) mem_phase($urandom_range(1, 63));
      else if ($urandom_range(0, 3) == 0) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      wait_for(1, "rnd_wait_s2");
      steps++;
      if (steps >= 6 || $urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) decide('0, 1'b1, 1'b0, nxt);
        else                           decide('0, 1'b0, 1'b1, nxt);
      end else begin
        decide(10'd1 << prio[$urandom_range(0, 8)], 1'b0, 1'b0, nxt);
      end
      cur = nxt;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nxt;
    #1;
    chk("init_flags", flags, 10'h3ff);
    chk("init_outs", {strob1, strob2, mem_req, kc, busy, alarm}, 0);
    repeat (2) @(posedge clk_sys);
    #1 clr_ = 1'b1;

    // Reset asserted in the middle of a WR memory wait.
    do_start();
    wait_for(0, "t1_s1"); wait_for(1, "t1_s2");
    decide(10'd1 << 6, 1'b0, 1'b0, nxt);
    tick(); tick();
    chk("t1_in_mw", mem_req, 1);
    do_reset();

    // PP -> WP -> end: pp_ low 3 clocks, wp_ low 2, kc right after WP S2.
    start = 1'b1;
    expq.push_back('{kind: 0, ph: 0, alm: alarm_exp});
    tick();
    start = 1'b0;
    chk("t2_pp_arm", pp_, 0); chk("t2_arm_no_s1", strob1, 0); chk("t2_arm_busy", busy, 1);
    tick(); chk("t2_pp_s1", pp_, 0); chk("t2_s1", strob1, 1);
    tick(); chk("t2_pp_s2", pp_, 0); chk("t2_s2", strob2, 1);
    decide(10'd1 << 4, 1'b0, 1'b0, nxt);
    chk("t2_pp_off", pp_, 1); chk("t2_wp_s1", wp_, 0);
    tick(); chk("t2_wp_s2", wp_, 0); chk("t2_wp_strob2", strob2, 1);
    decide('0, 1'b0, 1'b1, nxt);
    chk("t2_kc", kc, 1); chk("t2_wp_off", wp_, 1); chk("t2_alarm", alarm, 0);
    tick(); chk("t2_kc_once", kc, 0);

    // Memory phase: mem_ok at MW cycle 10, then exactly at the limit.
    foreach (prio[k]) if (k < 2) begin
      do_start();
      wait_for(0, "t3_s1"); wait_for(1, "t3_s2");
      decide(10'd1 << 6, 1'b0, 1'b0, nxt);
      wait_for(0, "t3_wr_s1");
      mem_phase(k == 0 ? 10 : 64);
      decide('0, 1'b1, 1'b0, nxt);
      tick();
    end

    // Memory timeout.
    do_start();
    wait_for(0, "t3t_s1"); wait_for(1, "t3t_s2");
    decide(10'd1 << 6, 1'b0, 1'b0, nxt);
    wait_for(0, "t3t_wr_s1");
    mem_phase(0);

    // Multiple enter requests, then end winning over ewx.
    do_start();
    wait_for(0, "t4_s1"); wait_for(1, "t4_s2");
    decide((10'd1 << 5) | (10'd1 << 3), 1'b0, 1'b0, nxt);
    chk("t4_wa", wa_, 0); chk("t4_we_off", we_, 1);
    wait_for(1, "t4_wa_s2");
    decide(10'd1 << 9, 1'b1, 1'b0, nxt);
    chk("t4_kc", kc, 1); chk("t4_no_wx", wx_, 1);
    tick();

    // Nothing requested in S2; a later start still runs with alarm kept.
    do_start();
    wait_for(0, "t5_s1"); wait_for(1, "t5_s2");
    decide('0, 1'b0, 1'b0, nxt);
    tick(); chk("t5_no_kc", kc, 0);
    do_start();
    wait_for(0, "t5b_s1"); wait_for(1, "t5b_s2");
    decide('0, 1'b0, 1'b1, nxt);
    chk("t5_alarm_sticky", alarm, 1);
    tick();

    do_reset();
    repeat (40) rand_instr();

    repeat (3) tick();
    chk("kc_count", kc_seen, kc_exp);
    chk("queue_empty", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
